// File: rtl/isa_ddr_writer.sv
// Streams a program of instruction words from the host into DDR as write bursts,
// using the same address mapping the instruction cache reads back with (addr << 3).
//
// state | meaning
// IDLE  | waiting for start; buffer flushed on an accepted start
// FILL  | waiting until the buffer holds a full burst (min(BURST_LEN, remaining))
// BURST | burst request held; controller pops words with wr_burst_data_req
// NEXT  | advance address/remaining after a burst; also the landing spot for rejected loads
// DONE  | one-cycle done pulse, then back to IDLE
module isa_ddr_writer #(
    parameter int ISA_WIDTH       = 30,
    parameter int ADDR_WIDTH_MEM  = 16,
    parameter int DDR_ADDR_WIDTH  = 28,
    parameter int DDR_DATA_WIDTH  = 64,
    parameter int TOTAL_ISA_DEPTH = 128,
    parameter int BURST_LEN       = 8,
    parameter int BUF_DEPTH       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_WIDTH_MEM-1:0] base_ins_addr,
    input  logic [9:0]                ins_count,
    input  logic                      ins_in_valid,
    input  logic [ISA_WIDTH-1:0]      ins_in,
    output logic                      ins_in_ready,
    output logic                      wr_burst_req,
    output logic [9:0]                wr_burst_len,
    output logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr,
    input  logic                      wr_burst_data_req,
    output logic [DDR_DATA_WIDTH-1:0] wr_burst_data,
    input  logic                      wr_burst_finish,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [9:0]                ins_written
);

    localparam int PTR_W = $clog2(BUF_DEPTH);

    typedef enum logic [2:0] {IDLE, FILL, BURST, NEXT, DONE} state_t;

    state_t                    state;
    logic [ISA_WIDTH-1:0]      buf_mem [BUF_DEPTH];
    logic [PTR_W-1:0]          rd_ptr;
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W:0]            buf_cnt;
    logic [ADDR_WIDTH_MEM-1:0] cur_addr;
    logic [9:0]                count_lat;
    logic [9:0]                remaining;
    logic [9:0]                accepted;
    logic [9:0]                burst_cnt;
    logic [9:0]                blen;
    logic [ADDR_WIDTH_MEM:0]   end_addr;
    logic                      start_ok;
    logic                      buf_full;
    logic                      buf_empty;
    logic                      req_ok;
    logic                      push;
    logic                      pop;
    logic                      range_bad;

    assign start_ok     = (state == IDLE) && start;
    assign buf_full     = (buf_cnt == (PTR_W+1)'(BUF_DEPTH));
    assign buf_empty    = (buf_cnt == '0);
    assign ins_in_ready = busy && !buf_full && (accepted < count_lat);
    assign push         = ins_in_valid && ins_in_ready;
    assign req_ok       = (state == BURST) && !buf_empty && (burst_cnt < wr_burst_len);
    assign pop          = wr_burst_data_req && req_ok;
    assign wr_burst_data = req_ok ? DDR_DATA_WIDTH'(buf_mem[rd_ptr]) : '0;
    assign blen         = (remaining > 10'(BURST_LEN)) ? 10'(BURST_LEN) : remaining;
    assign end_addr     = {1'b0, base_ins_addr} + (ADDR_WIDTH_MEM+1)'(ins_count);
    assign range_bad    = (ins_count > 10'(TOTAL_ISA_DEPTH)) ||
                          (end_addr > {1'b1, {ADDR_WIDTH_MEM{1'b0}}});

    always_ff @(posedge clk) begin
        if (push)
            buf_mem[wr_ptr] <= ins_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            buf_cnt <= '0;
        end else if (start_ok) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            buf_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   buf_cnt <= buf_cnt + 1'b1;
                2'b01:   buf_cnt <= buf_cnt - 1'b1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cur_addr      <= '0;
            count_lat     <= '0;
            remaining     <= '0;
            accepted      <= '0;
            burst_cnt     <= '0;
            wr_burst_req  <= 1'b0;
            wr_burst_len  <= '0;
            wr_burst_addr <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            ins_written   <= '0;
        end else begin
            done <= 1'b0;
            if (push)
                accepted <= accepted + 1'b1;
            if (pop) begin
                ins_written <= ins_written + 1'b1;
                burst_cnt   <= burst_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr     <= base_ins_addr;
                        accepted     <= '0;
                        burst_cnt    <= '0;
                        ins_written  <= '0;
                        wr_burst_len <= '0;
                        busy         <= 1'b1;
                        // Rejected/empty loads go through NEXT with nothing left,
                        // which gives them the same done latency as a real load.
                        if ((ins_count == '0) || range_bad) begin
                            count_lat <= '0;
                            remaining <= '0;
                            err       <= range_bad;
                            state     <= NEXT;
                        end else begin
                            count_lat <= ins_count;
                            remaining <= ins_count;
                            err       <= 1'b0;
                            state     <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (10'(buf_cnt) >= blen) begin
                        wr_burst_len  <= blen;
                        wr_burst_addr <= DDR_ADDR_WIDTH'({cur_addr, 3'b000});
                        wr_burst_req  <= 1'b1;
                        burst_cnt     <= '0;
                        state         <= BURST;
                    end
                end
                BURST: begin
                    if (wr_burst_data_req && !req_ok)
                        err <= 1'b1;
                    if (wr_burst_finish) begin
                        wr_burst_req <= 1'b0;
                        state        <= NEXT;
                    end
                end
                NEXT: begin
                    cur_addr  <= cur_addr + ADDR_WIDTH_MEM'(wr_burst_len);
                    remaining <= remaining - wr_burst_len;
                    if (remaining == wr_burst_len) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        state <= FILL;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_isa_ddr_writer.sv
// Self-checking bench for isa_ddr_writer: vector table of loads, hand sequences for
// protocol errors and mid-burst reset, and random loads against a burst/word model.
module tb_isa_ddr_writer;

    localparam int ISA_W = 30;
    localparam int BUF   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_ins_addr;
    logic [9:0]  ins_count;
    logic        ins_in_valid;
    logic [29:0] ins_in;
    logic        ins_in_ready;
    logic        wr_burst_req;
    logic [9:0]  wr_burst_len;
    logic [27:0] wr_burst_addr;
    logic        wr_burst_data_req;
    logic [63:0] wr_burst_data;
    logic        wr_burst_finish;
    logic        busy;
    logic        done;
    logic        err;
    logic [9:0]  ins_written;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    isa_ddr_writer dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .base_ins_addr     (base_ins_addr),
        .ins_count         (ins_count),
        .ins_in_valid      (ins_in_valid),
        .ins_in            (ins_in),
        .ins_in_ready      (ins_in_ready),
        .wr_burst_req      (wr_burst_req),
        .wr_burst_len      (wr_burst_len),
        .wr_burst_addr     (wr_burst_addr),
        .wr_burst_data_req (wr_burst_data_req),
        .wr_burst_data     (wr_burst_data),
        .wr_burst_finish   (wr_burst_finish),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .ins_written       (ins_written)
    );

    typedef struct {
        logic [15:0] base;
        int          count;
        int          vpct;
        int          rpct;
        int          hold;
        bit          extra;
        bit          exp_err;
        bit          quick;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        start             = 1'b0;
        ins_in_valid      = 1'b0;
        wr_burst_data_req = 1'b0;
        wr_burst_finish   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},     wr_burst_req, 0);
        check({tag, "_len"},     wr_burst_len, 0);
        check({tag, "_addr"},    wr_burst_addr, 0);
        check({tag, "_data"},    wr_burst_data, 0);
        check({tag, "_ready"},   ins_in_ready, 0);
        check({tag, "_busy"},    busy, 0);
        check({tag, "_done"},    done, 0);
        check({tag, "_err"},     err, 0);
        check({tag, "_written"}, ins_written, 0);
    endtask

    task automatic pulse_start(input logic [15:0] b, input int c);
        base_ins_addr = b;
        ins_count     = 10'(c);
        start         = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Empty or rejected load: done two cycles after start, busy only in between.
    task automatic run_quick(input logic [15:0] b, input int c, input bit exp_err);
        ins_in_valid = 1'b1;
        pulse_start(b, c);
        check("q_busy_c1",  busy, 1);
        check("q_done_c1",  done, 0);
        check("q_ready_c1", ins_in_ready, 0);
        check("q_err_c1",   err, exp_err);
        tick();
        check("q_done_c2",  done, 1);
        check("q_busy_c2",  busy, 0);
        check("q_err_c2",   err, exp_err);
        check("q_req_c2",   wr_burst_req, 0);
        tick();
        check("q_done_c3",  done, 0);
        check("q_err_c3",   err, exp_err);
        check("q_req_c3",   wr_burst_req, 0);
        check("q_written",  ins_written, 0);
        ins_in_valid = 1'b0;
    endtask

    task automatic run_load(input logic [15:0] b, input int c, input int vpct, input int rpct,
                            input int hold, input bit extra, input bit exp_err, input int abort_after);
        logic [ISA_W-1:0] sent_q[$];
        int blen_q[$];
        int addr_q[$];
        int acc = 0;
        int popped = 0;
        int cyc = 1;
        int fin_cyc = -100;
        int extra_cyc = -100;
        int given = 0;
        int cur_len = 0;
        int age = 0;
        int max_occ = 0;
        bit in_burst = 1'b0;
        bit extra_done = 1'b0;
        bit done_seen = 1'b0;

        for (int off = 0; off < c; off += 8) begin
            blen_q.push_back((c - off < 8) ? c - off : 8);
            addr_q.push_back((int'(b) + off) * 8);
        end
        pulse_start(b, c);
        check("err_cleared_by_start", err, 0);
        while (cyc < 4000) begin
            if (done) begin
                done_seen = 1'b1;
                check("done_latency",   cyc - fin_cyc, 2);
                check("busy_at_done",   busy, 0);
                check("ready_at_done",  ins_in_ready, 0);
                check("written_total",  ins_written, c);
                check("accepted_total", acc, c);
                check("err_final",      err, exp_err);
                check("bursts_left",    blen_q.size(), 0);
                break;
            end
            check("busy",    busy, 1);
            check("ready",   ins_in_ready, ((acc - popped) < BUF) && (acc < c));
            check("written", ins_written, popped);
            if (fin_cyc == cyc - 1)
                check("req_drop", wr_burst_req, 0);
            if (extra_cyc == cyc - 1)
                check("err_on_extra_req", err, 1);
            if (abort_after > 0 && popped == abort_after) begin
                rst = 1'b1;
                idle_inputs();
                tick();
                check_reset_outputs("abort");
                for (int k = 0; k < 3; k++) begin
                    tick();
                    check("no_done_in_reset", done, 0);
                end
                rst = 1'b0;
                tick();
                check("busy_after_reset", busy, 0);
                return;
            end

            wr_burst_data_req = 1'b0;
            wr_burst_finish   = 1'b0;
            if (wr_burst_req) begin
                if (!in_burst) begin
                    in_burst = 1'b1;
                    given    = 0;
                    age      = 0;
                    if (blen_q.size() == 0) begin
                        check("unexpected_burst", wr_burst_req, 0);
                        cur_len = 0;
                    end else begin
                        cur_len = blen_q.pop_front();
                        check("burst_len",  wr_burst_len, cur_len);
                        check("burst_addr", wr_burst_addr, addr_q.pop_front());
                    end
                end
                age++;
                if (given < cur_len) begin
                    if (age > hold && $urandom_range(1, 100) <= rpct) begin
                        if (sent_q.size() == 0) begin
                            check("model_buffer_nonempty", sent_q.size(), 1);
                        end else begin
                            wr_burst_data_req = 1'b1;
                            check("data_word", wr_burst_data, 64'(sent_q.pop_front()));
                            given++;
                            popped++;
                        end
                    end
                end else if (extra && !extra_done) begin
                    wr_burst_data_req = 1'b1;
                    extra_done = 1'b1;
                    extra_cyc  = cyc;
                    check("data_on_extra_req", wr_burst_data, 0);
                end else begin
                    wr_burst_finish = 1'b1;
                    fin_cyc  = cyc;
                    in_burst = 1'b0;
                end
            end

            ins_in       = 30'($urandom);
            ins_in_valid = ($urandom_range(1, 100) <= vpct);
            if (ins_in_valid && ins_in_ready) begin
                sent_q.push_back(ins_in);
                acc++;
            end
            if (acc - popped > max_occ)
                max_occ = acc - popped;
            tick();
            cyc++;
        end
        check("load_done_seen", done_seen, 1);
        idle_inputs();
        tick();
        check("done_single_pulse", done, 0);
        if (hold >= 20)
            check("buffer_reached_full", max_occ, BUF);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        //          base      cnt  vpct rpct hold extra err  quick
        vecs[0]  = '{16'h0010,   8, 100, 100,  0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'h0100,  19,  70,  60,  0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{16'h0100,  19, 100, 100, 30, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{16'h0000,   0, 100, 100,  0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{16'h0000, 129, 100, 100,  0, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{16'hFFFC,   8, 100, 100,  0, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{16'h0200,   8, 100, 100,  0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{16'hFFF8,   8, 100,  50,  0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{16'h0000, 128,  90,  80,  0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{16'h0300,   8, 100, 100,  0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{16'h0040,  16, 100, 100,  3, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{16'h0050,   5,  60,  70,  0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        base_ins_addr = '0;
        ins_count     = '0;
        ins_in        = '0;
        idle_inputs();
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].quick)
                run_quick(vecs[i].base, vecs[i].count, vecs[i].exp_err);
            else
                run_load(vecs[i].base, vecs[i].count, vecs[i].vpct, vecs[i].rpct,
                         vecs[i].hold, vecs[i].extra, vecs[i].exp_err, 0);
            tick();
        end

        // Reset after 3 of 8 words, then a clean reload.
        run_load(16'h0020, 8, 100, 100, 0, 1'b0, 1'b0, 3);
        run_load(16'h0020, 8, 100, 100, 0, 1'b0, 1'b0, 0);

        for (int r = 0; r < 6; r++) begin
            int c;
            logic [15:0] b;
            c = int'($urandom_range(1, 128));
            b = 16'($urandom_range(0, 65536 - c));
            run_load(b, c, int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                     int'($urandom_range(0, 12)), 1'b0, 1'b0, 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
